// File: rtl/csr_timer_unit_if.sv
// CSR access, exception/ertn commit and interrupt bundle for csr_timer_unit.
// ID drives reads, WB drives writes and commits; the CSR unit is the slave.
interface csr_timer_unit_if #(
  parameter int HW_INT_N = 8
);
  logic                csr_re;
  logic [13:0]         csr_num;
  logic [31:0]         csr_rvalue;
  logic                csr_we;
  logic [31:0]         csr_wmask;
  logic [31:0]         csr_wvalue;
  logic [31:0]         ex_entry;
  logic [31:0]         ertn_entry;
  logic                has_int;
  logic                ertn_flush;
  logic                wb_ex;
  logic [5:0]          wb_ecode;
  logic [8:0]          wb_esubcode;
  logic [31:0]         wb_pc;
  logic [31:0]         wb_vaddr;
  logic [HW_INT_N-1:0] hw_int_in;
  logic                ipi_int_in;

  modport slave (
    input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    input  ertn_flush, wb_ex, wb_ecode, wb_esubcode,
    input  wb_pc, wb_vaddr, hw_int_in, ipi_int_in,
    output csr_rvalue, ex_entry, ertn_entry, has_int
  );

  modport master (
    output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    output ertn_flush, wb_ex, wb_ecode, wb_esubcode,
    output wb_pc, wb_vaddr, hw_int_in, ipi_int_in,
    input  csr_rvalue, ex_entry, ertn_entry, has_int
  );
endinterface

// File: rtl/csr_timer_unit.sv
// LoongArch-32 CSR file with constant timer and sampled interrupts.
// Define CSR_BADV_EN to implement the BADV register (0x07).
module csr_timer_unit #(
  parameter int          TIMER_W  = 32,
  parameter int          HW_INT_N = 8,
  parameter int          SAVE_N   = 4,
  parameter logic [31:0] TID_INIT = 32'h0
) (
  input logic             clk,
  input logic             reset,
  csr_timer_unit_if.slave bus
);
  localparam logic [13:0] A_CRMD   = 14'h00;
  localparam logic [13:0] A_PRMD   = 14'h01;
  localparam logic [13:0] A_ECFG   = 14'h04;
  localparam logic [13:0] A_ESTAT  = 14'h05;
  localparam logic [13:0] A_ERA    = 14'h06;
  localparam logic [13:0] A_BADV   = 14'h07;
  localparam logic [13:0] A_EENTRY = 14'h0c;
  localparam logic [13:0] A_SAVE0  = 14'h30;
  localparam logic [13:0] A_TID    = 14'h40;
  localparam logic [13:0] A_TCFG   = 14'h41;
  localparam logic [13:0] A_TVAL   = 14'h42;
  localparam logic [13:0] A_TICLR  = 14'h44;
  localparam int          SI_W     = (SAVE_N > 1) ? $clog2(SAVE_N) : 1;
  localparam logic [12:0] LIE_MASK = 13'h1bff;

  logic [8:0]         r_crmd;
  logic [2:0]         r_prmd;
  logic [12:0]        r_lie;
  logic [1:0]         r_is_sw;
  logic [7:0]         r_is_hw;
  logic               r_is_ti;
  logic               r_is_ipi;
  logic [5:0]         r_ecode;
  logic [8:0]         r_esub;
  logic [31:0]        r_era;
  logic [25:0]        r_eentry;
  logic [31:0]        r_save [SAVE_N];
  logic [31:0]        r_tid;
  logic [TIMER_W-1:0] r_tcfg;
  logic [TIMER_W-1:0] r_cnt;

  logic [31:0]        w_m;
  logic [31:0]        w_v;
  logic [31:0]        w_estat;
  logic [7:0]         w_hw;
  logic [SI_W-1:0]    w_sidx;
  logic               w_in_save;
  logic               w_wr_save;
  logic [TIMER_W-1:0] w_tcfg_new;
  logic               w_ti_fire;
  logic               w_ti_clr;
  logic [31:0]        w_rdata;

  assign w_m = bus.csr_wmask;
  assign w_v = bus.csr_wvalue;

  function automatic logic [31:0] f_mw(
    input logic [31:0] old,
    input logic [31:0] m,
    input logic [31:0] v
  );
    return (m & v) | (~m & old);
  endfunction

  function automatic logic wr_to(input logic [13:0] a);
    return bus.csr_we && (bus.csr_num == a);
  endfunction

  always_comb begin
    w_hw = '0;
    w_hw[HW_INT_N-1:0] = bus.hw_int_in;
  end

  assign w_sidx    = bus.csr_num[SI_W-1:0];
  assign w_in_save = (bus.csr_num >= A_SAVE0) &&
                     (bus.csr_num < A_SAVE0 + 14'(SAVE_N));
  assign w_wr_save = bus.csr_we && w_in_save;

  assign w_tcfg_new = (w_m[TIMER_W-1:0] & w_v[TIMER_W-1:0]) |
                      (~w_m[TIMER_W-1:0] & r_tcfg);
  assign w_ti_fire  = r_tcfg[0] && (r_cnt == '0);
  assign w_ti_clr   = wr_to(A_TICLR) && w_m[0] && w_v[0];

  assign w_estat = {1'b0, r_esub, r_ecode, 3'b0, r_is_ipi,
                    r_is_ti, 1'b0, r_is_hw, r_is_sw};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crmd <= 9'h008;
    end else if (bus.wb_ex) begin
      r_crmd[2:0] <= 3'b0;
    end else if (bus.ertn_flush) begin
      r_crmd[2:0] <= r_prmd;
    end else if (wr_to(A_CRMD)) begin
      r_crmd <= (w_m[8:0] & w_v[8:0]) | (~w_m[8:0] & r_crmd);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prmd <= '0;
      r_era  <= '0;
    end else if (bus.wb_ex) begin
      r_prmd <= r_crmd[2:0];
      r_era  <= bus.wb_pc;
    end else begin
      if (wr_to(A_PRMD))
        r_prmd <= (w_m[2:0] & w_v[2:0]) | (~w_m[2:0] & r_prmd);
      if (wr_to(A_ERA))
        r_era <= f_mw(r_era, w_m, w_v);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lie    <= '0;
      r_eentry <= '0;
      r_tid    <= TID_INIT;
    end else begin
      if (wr_to(A_ECFG))
        r_lie <= ((w_m[12:0] & w_v[12:0]) | (~w_m[12:0] & r_lie))
                 & LIE_MASK;
      if (wr_to(A_EENTRY))
        r_eentry <= (w_m[31:6] & w_v[31:6]) | (~w_m[31:6] & r_eentry);
      if (wr_to(A_TID))
        r_tid <= f_mw(r_tid, w_m, w_v);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SAVE_N; i++) r_save[i] <= '0;
    end else begin
      for (int i = 0; i < SAVE_N; i++)
        if (w_wr_save && (w_sidx == SI_W'(i)))
          r_save[i] <= f_mw(r_save[i], w_m, w_v);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_sw  <= '0;
      r_is_hw  <= '0;
      r_is_ipi <= 1'b0;
      r_ecode  <= '0;
      r_esub   <= '0;
    end else begin
      r_is_hw  <= w_hw;
      r_is_ipi <= bus.ipi_int_in;
      if (bus.wb_ex) begin
        r_ecode <= bus.wb_ecode;
        r_esub  <= bus.wb_esubcode;
      end else if (wr_to(A_ESTAT)) begin
        r_is_sw <= (w_m[1:0] & w_v[1:0]) | (~w_m[1:0] & r_is_sw);
      end
    end
  end

  // Timer expiry set takes precedence over a same-cycle TICLR clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_is_ti <= 1'b0;
    else if (w_ti_fire) r_is_ti <= 1'b1;
    else if (w_ti_clr)  r_is_ti <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tcfg <= '0;
      r_cnt  <= '0;
    end else if (wr_to(A_TCFG)) begin
      r_tcfg <= w_tcfg_new;
      r_cnt  <= {w_tcfg_new[TIMER_W-1:2], 2'b00};
    end else if (r_tcfg[0]) begin
      if (r_cnt == '0)
        r_cnt <= r_tcfg[1] ? {r_tcfg[TIMER_W-1:2], 2'b00} : '1;
      else if (r_cnt != '1)
        r_cnt <= r_cnt - 1'b1;
    end
  end

`ifdef CSR_BADV_EN
  logic [31:0] r_badv;
  logic        w_unused;
  assign w_unused = bus.csr_re;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_badv <= '0;
    else if (bus.wb_ex && bus.wb_ecode == 6'h08)
      r_badv <= bus.wb_pc;
    else if (bus.wb_ex && bus.wb_ecode == 6'h09)
      r_badv <= bus.wb_vaddr;
    else if (!bus.wb_ex && wr_to(A_BADV))
      r_badv <= f_mw(r_badv, w_m, w_v);
  end
`else
  logic w_unused;
  assign w_unused = ^{bus.csr_re, bus.wb_vaddr};
`endif

  always_comb begin
    w_rdata = '0;
    if (w_in_save) begin
      w_rdata = r_save[w_sidx];
    end else begin
      case (bus.csr_num)
        A_CRMD:   w_rdata = 32'(r_crmd);
        A_PRMD:   w_rdata = 32'(r_prmd);
        A_ECFG:   w_rdata = 32'(r_lie);
        A_ESTAT:  w_rdata = w_estat;
        A_ERA:    w_rdata = r_era;
`ifdef CSR_BADV_EN
        A_BADV:   w_rdata = r_badv;
`endif
        A_EENTRY: w_rdata = {r_eentry, 6'b0};
        A_TID:    w_rdata = r_tid;
        A_TCFG:   w_rdata = 32'(r_tcfg);
        A_TVAL:   w_rdata = 32'(r_cnt);
        default:  w_rdata = '0;
      endcase
    end
  end

  assign bus.csr_rvalue = w_rdata;
  assign bus.ex_entry   = {r_eentry, 6'b0};
  assign bus.ertn_entry = r_era;
  assign bus.has_int    = |(w_estat[12:0] & r_lie) & r_crmd[2];
endmodule
